// File: rtl/pixel_queue_pkg.sv
// Shared widths, entry layout and FSM encoding for the pixel request queue.
package pixel_queue_pkg;

  localparam int PIXEL_COORD_BITS = 8;
  localparam int PIXEL_RGB_BITS   = 8;
  localparam int PIXEL_ENTRY_BITS = 2 * PIXEL_COORD_BITS + PIXEL_RGB_BITS;

  typedef struct packed {
    logic [PIXEL_COORD_BITS-1:0] x;
    logic [PIXEL_COORD_BITS-1:0] y;
    logic [PIXEL_RGB_BITS-1:0]   rgb;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_queue_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy; dout is read
// combinationally at the read pointer, so a pop consumes what dout shows.
module sync_fifo
  import pixel_queue_pkg::*;
#(
  parameter int WIDTH     = PIXEL_ENTRY_BITS,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [ADDR_BITS-1:0] PTR_STEP   = 1;
  localparam logic [ADDR_BITS:0]   CNT_STEP   = 1;
  localparam logic [ADDR_BITS:0]   FULL_COUNT = DEPTH[ADDR_BITS:0];

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  // Full refuses a push even if a pop frees a slot in the same cycle.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  assign full  = (r_count == FULL_COUNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_STEP;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_STEP;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_STEP;
        2'b01:   r_count <= r_count - CNT_STEP;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_queue.sv
// Buffers processor pixel writes and replays them one at a time into
// pixel_writer via pixel_en / pixel_wr_done, gated on the boot screen clear.
module pixel_queue
  import pixel_queue_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear_screen_done,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PIXEL_COORD_BITS-1:0] in_x,
  input  logic [PIXEL_COORD_BITS-1:0] in_y,
  input  logic [PIXEL_RGB_BITS-1:0]   in_rgb,
  output logic                        pixel_en,
  output logic [PIXEL_COORD_BITS-1:0] pixel_x,
  output logic [PIXEL_COORD_BITS-1:0] pixel_y,
  output logic [PIXEL_RGB_BITS-1:0]   pixel_rgb,
  input  logic                        pixel_wr_done,
  output logic [ADDR_BITS:0]          count,
  output logic                        overflow,
  output logic                        idle
);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic [PIXEL_ENTRY_BITS-1:0] w_din;
  logic [PIXEL_ENTRY_BITS-1:0] w_dout;
  pixel_t                      w_head;

  logic                        r_pixel_en;
  logic [PIXEL_COORD_BITS-1:0] r_pixel_x;
  logic [PIXEL_COORD_BITS-1:0] r_pixel_y;
  logic [PIXEL_RGB_BITS-1:0]   r_pixel_rgb;
  logic                        r_overflow;

  assign w_din    = {in_x, in_y, in_rgb};
  assign w_head   = pixel_t'(w_dout);
  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full;

  sync_fifo #(
    .WIDTH     (PIXEL_ENTRY_BITS),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && clear_screen_done && pixel_wr_done) begin
          w_state_nxt = ST_ISSUE;
          w_pop       = 1'b1;
        end
      end
      ST_ISSUE: w_state_nxt = ST_GUARD;
      // pixel_writer drops done a cycle after the strobe; ignore it here.
      ST_GUARD: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (pixel_wr_done) begin
          if (!w_empty) begin
            w_state_nxt = ST_ISSUE;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pixel_en  <= 1'b0;
      r_pixel_x   <= '0;
      r_pixel_y   <= '0;
      r_pixel_rgb <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pixel_en <= w_pop;
      if (w_pop) begin
        r_pixel_x   <= w_head.x;
        r_pixel_y   <= w_head.y;
        r_pixel_rgb <= w_head.rgb;
      end
      if (in_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign pixel_en  = r_pixel_en;
  assign pixel_x   = r_pixel_x;
  assign pixel_y   = r_pixel_y;
  assign pixel_rgb = r_pixel_rgb;
  assign overflow  = r_overflow;
  assign idle      = w_empty & (r_state == ST_IDLE);

endmodule

// File: tb/tb_pixel_queue.sv
// Directed bench for pixel_queue: latency, full/overflow, slow writer,
// full-queue push/pop, asynchronous reset and back-to-back issue spacing.
module tb_pixel_queue;

  logic       clk;
  logic       reset;
  logic       clear_screen_done;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic [7:0] in_rgb;
  logic       pixel_en;
  logic [7:0] pixel_x;
  logic [7:0] pixel_y;
  logic [7:0] pixel_rgb;
  logic       pixel_wr_done;
  logic [4:0] count;
  logic       overflow;
  logic       idle;

  int vecs;
  int errs;

  pixel_queue #(.DEPTH(16), .ADDR_BITS(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .clear_screen_done (clear_screen_done),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_x              (in_x),
    .in_y              (in_y),
    .in_rgb            (in_rgb),
    .pixel_en          (pixel_en),
    .pixel_x           (pixel_x),
    .pixel_y           (pixel_y),
    .pixel_rgb         (pixel_rgb),
    .pixel_wr_done     (pixel_wr_done),
    .count             (count),
    .overflow          (overflow),
    .idle              (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int i);
    logic [7:0] a, b, c;
    a = 8'(i * 7 + 3);
    b = 8'(200 - i);
    c = 8'(i * 37 + 5);
    return {a, b, c};
  endfunction

  task automatic set_pix(input logic [23:0] p);
    {in_x, in_y, in_rgb} = p;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    set_pix(24'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_n(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      set_pix(pix(base + i));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    clear_screen_done = 1'b1;
    pixel_wr_done = 1'b1;
    do_reset();
    vecs++;
    if ({in_ready, pixel_en, overflow, idle} !== 4'b1001) begin
      errs++; $display("FAIL reset_flags: got %b expected 1001", {in_ready, pixel_en, overflow, idle});
    end
    vecs++;
    if ({pixel_x, pixel_y, pixel_rgb, count} !== 29'h0) begin
      errs++; $display("FAIL reset_data: got %h/%h/%h cnt %0d expected zeros", pixel_x, pixel_y, pixel_rgb, count);
    end
  endtask

  task automatic test_single;
    do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_x = 8'd10; in_y = 8'd20; in_rgb = 8'hE0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vecs++;
    if (pixel_en !== 1'b0 || count !== 5'd1) begin
      errs++; $display("FAIL single_c1: got en %b cnt %0d expected en 0 cnt 1", pixel_en, count);
    end
    @(posedge clk); #1;
    vecs++;
    if (pixel_en !== 1'b1 || {pixel_x, pixel_y, pixel_rgb} !== {8'd10, 8'd20, 8'hE0} || count !== 5'd0) begin
      errs++; $display("FAIL single_c2: got en %b %h cnt %0d expected en 1 0a14e0 cnt 0",
                       pixel_en, {pixel_x, pixel_y, pixel_rgb}, count);
    end
    @(posedge clk); #1;
    vecs++;
    if (pixel_en !== 1'b0 || pixel_x !== 8'd10) begin
      errs++; $display("FAIL single_c3: got en %b x %0d expected en 0 x 10", pixel_en, pixel_x);
    end
    @(posedge clk); #1;
    vecs++;
    if (idle !== 1'b0) begin
      errs++; $display("FAIL single_wait_idle: got %b expected 0", idle);
    end
    @(posedge clk); #1;
    vecs++;
    if (idle !== 1'b1) begin
      errs++; $display("FAIL single_idle: got %b expected 1", idle);
    end
  endtask

  task automatic test_full_overflow;
    int got;
    logic seen;
    do_reset();
    clear_screen_done = 1'b0;
    pixel_wr_done = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      set_pix(pix(i));
      @(posedge clk); #1;
      if (pixel_en) seen = 1'b1;
    end
    in_valid = 1'b0;
    vecs++;
    if (count !== 5'd16 || in_ready !== 1'b0 || overflow !== 1'b0) begin
      errs++; $display("FAIL full_16: got cnt %0d rdy %b ovf %b expected 16 0 0", count, in_ready, overflow);
    end
    @(negedge clk);
    in_valid = 1'b1;
    set_pix(pix(99));
    @(posedge clk); #1;
    in_valid = 1'b0;
    vecs++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errs++; $display("FAIL overflow_17: got ovf %b cnt %0d expected 1 16", overflow, count);
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (pixel_en) seen = 1'b1;
    end
    vecs++;
    if (seen !== 1'b0) begin
      errs++; $display("FAIL no_issue_before_clear: got pixel_en seen %b expected 0", seen);
    end
    clear_screen_done = 1'b1;
    got = 0;
    for (int c = 0; c < 300 && got < 16; c++) begin
      @(posedge clk); #1;
      if (pixel_en) begin
        vecs++;
        if ({pixel_x, pixel_y, pixel_rgb} !== pix(got)) begin
          errs++; $display("FAIL drain_order[%0d]: got %h expected %h", got, {pixel_x, pixel_y, pixel_rgb}, pix(got));
        end
        got++;
      end
    end
    vecs++;
    if (got != 16 || count !== 5'd0) begin
      errs++; $display("FAIL drain_count: got %0d pops cnt %0d expected 16 pops cnt 0", got, count);
    end
  endtask

  task automatic test_slow_done;
    logic bad;
    do_reset();
    clear_screen_done = 1'b1;
    pixel_wr_done = 1'b0;
    push_n(20, 3);
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (pixel_en) bad = 1'b1;
    end
    vecs++;
    if (bad !== 1'b0 || count !== 5'd3) begin
      errs++; $display("FAIL slow_hold: got en_seen %b cnt %0d expected 0 3", bad, count);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pixel_wr_done = 1'b1;
      @(posedge clk); #1;
      vecs++;
      if (pixel_en !== 1'b1 || {pixel_x, pixel_y, pixel_rgb} !== pix(20 + k) || count !== 5'(2 - k)) begin
        errs++; $display("FAIL slow_issue[%0d]: got en %b %h cnt %0d expected en 1 %h cnt %0d",
                         k, pixel_en, {pixel_x, pixel_y, pixel_rgb}, count, pix(20 + k), 2 - k);
      end
      pixel_wr_done = 1'b0;
      bad = 1'b0;
      repeat (50) begin
        @(posedge clk); #1;
        if (pixel_en !== 1'b0 || {pixel_x, pixel_y, pixel_rgb} !== pix(20 + k)) bad = 1'b1;
      end
      vecs++;
      if (bad !== 1'b0) begin
        errs++; $display("FAIL slow_stable[%0d]: got disturbance %b expected 0", k, bad);
      end
    end
    @(negedge clk);
    pixel_wr_done = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (idle !== 1'b1) begin
      errs++; $display("FAIL slow_idle: got %b expected 1", idle);
    end
  endtask

  task automatic test_full_pushpop;
    int got;
    int n;
    do_reset();
    clear_screen_done = 1'b0;
    pixel_wr_done = 1'b1;
    push_n(0, 16);
    @(negedge clk);
    in_valid = 1'b1;
    set_pix(pix(16));
    clear_screen_done = 1'b1;
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++; $display("FAIL pushpop_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    vecs++;
    if (count !== 5'd15 || pixel_en !== 1'b1 || {pixel_x, pixel_y, pixel_rgb} !== pix(0)) begin
      errs++; $display("FAIL pushpop_refused: got cnt %0d en %b %h expected 15 1 %h",
                       count, pixel_en, {pixel_x, pixel_y, pixel_rgb}, pix(0));
    end
    got = 1;
    n = 16;
    fork
      begin
        for (int c = 0; c < 3000 && n < 40; c++) begin
          @(negedge clk);
          in_valid = 1'b1;
          set_pix(pix(n));
          if (in_ready) begin
            @(posedge clk);
            n++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 3000 && got < 40; c++) begin
          @(posedge clk); #1;
          if (pixel_en) begin
            vecs++;
            if ({pixel_x, pixel_y, pixel_rgb} !== pix(got)) begin
              errs++; $display("FAIL wrap_order[%0d]: got %h expected %h", got, {pixel_x, pixel_y, pixel_rgb}, pix(got));
            end
            got++;
          end
        end
      end
    join
    vecs++;
    if (got != 40 || n != 40 || count !== 5'd0) begin
      errs++; $display("FAIL wrap_total: got pops %0d pushes %0d cnt %0d expected 40 40 0", got, n, count);
    end
  endtask

  task automatic test_async_reset;
    int hits;
    do_reset();
    clear_screen_done = 1'b1;
    pixel_wr_done = 1'b0;
    push_n(80, 6);
    @(negedge clk);
    pixel_wr_done = 1'b1;
    @(posedge clk); #1;
    pixel_wr_done = 1'b0;
    vecs++;
    if (pixel_en !== 1'b1 || {pixel_x, pixel_y, pixel_rgb} !== pix(80)) begin
      errs++; $display("FAIL arst_first: got en %b %h expected 1 %h", pixel_en, {pixel_x, pixel_y, pixel_rgb}, pix(80));
    end
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (count !== 5'd5 || idle !== 1'b0) begin
      errs++; $display("FAIL arst_wait: got cnt %0d idle %b expected 5 0", count, idle);
    end
    #2;
    reset = 1'b1;
    #1;
    vecs++;
    if (count !== 5'd0 || pixel_en !== 1'b0 || idle !== 1'b1 || in_ready !== 1'b1) begin
      errs++; $display("FAIL arst_wait_clear: got cnt %0d en %b idle %b rdy %b expected 0 0 1 1",
                       count, pixel_en, idle, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    pixel_wr_done = 1'b1;
    hits = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (pixel_en) hits++;
    end
    vecs++;
    if (hits != 0 || count !== 5'd0) begin
      errs++; $display("FAIL arst_stale: got %0d pulses cnt %0d expected 0 0", hits, count);
    end
    push_n(90, 1);
    @(posedge clk); #1;
    vecs++;
    if (pixel_en !== 1'b1) begin
      errs++; $display("FAIL arst_issue_pre: got en %b expected 1", pixel_en);
    end
    #2;
    reset = 1'b1;
    #1;
    vecs++;
    if (pixel_en !== 1'b0 || {pixel_x, pixel_y, pixel_rgb} !== 24'h0) begin
      errs++; $display("FAIL arst_issue_drop: got en %b %h expected 0 000000", pixel_en, {pixel_x, pixel_y, pixel_rgb});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    int hits;
    int edge_at [8];
    logic [23:0] data_at [8];
    do_reset();
    clear_screen_done = 1'b1;
    pixel_wr_done = 1'b1;
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      in_valid = (k < 8);
      set_pix(pix(60 + k));
      @(posedge clk); #1;
      if (pixel_en) begin
        if (hits < 8) begin
          edge_at[hits] = k;
          data_at[hits] = {pixel_x, pixel_y, pixel_rgb};
        end
        hits++;
      end
    end
    in_valid = 1'b0;
    vecs++;
    if (hits != 8) begin
      errs++; $display("FAIL b2b_count: got %0d pulses expected 8", hits);
    end else begin
      for (int j = 0; j < 8; j++) begin
        vecs++;
        if (edge_at[j] != 1 + 3 * j || data_at[j] !== pix(60 + j)) begin
          errs++; $display("FAIL b2b[%0d]: got edge %0d data %h expected edge %0d data %h",
                           j, edge_at[j], data_at[j], 1 + 3 * j, pix(60 + j));
        end
      end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_x = 8'h0; in_y = 8'h0; in_rgb = 8'h0;
    clear_screen_done = 1'b1;
    pixel_wr_done = 1'b1;
    test_reset();
    test_single();
    test_full_overflow();
    test_slow_done();
    test_full_pushpop();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
